// File: rtl/ram_fill_check_master.sv
// Avalon-MM memory self-test master: fills a word range with a pattern, reads it back and
// counts miscompares. One access outstanding at a time; strobes are registered outputs.
module ram_fill_check_master #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     len,
    input  logic                mode,
    input  logic [DATA_W-1:0]   pattern,
    output logic                busy,
    output logic                done,
    output logic                err_flag,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_read,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRwait, StFin} state_e;

    localparam logic [ADDR_W:0]   MaxLen  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CntMax  = '1;
    localparam logic [ADDR_W:0]   IdxOne  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [2:0]        LatLast = 3'(READ_LATENCY - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   pattern_q, pattern_d;
    logic [2:0]          lat_q, lat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_flag_q, err_flag_d;
    logic [ADDR_W:0]     err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [ADDR_W:0]     len_eff;
    logic                last_word;
    logic [ADDR_W-1:0]   next_addr;

    function automatic logic [DATA_W-1:0] fill_word(input logic m, input logic [DATA_W-1:0] p,
                                                     input logic [ADDR_W-1:0] a);
        return m ? (p ^ DATA_W'(a)) : p;
    endfunction

    assign len_eff   = (len > MaxLen) ? MaxLen : len;
    assign last_word = (idx_q == (len_q - IdxOne));
    assign next_addr = addr_q + AddrOne;

    // Next-state and registered-output computation for the whole test sequence
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_flag_d  = 1'b0;
                    err_count_d = '0;
                    first_err_d = '0;
                    base_d      = base;
                    len_d       = len_eff;
                    mode_d      = mode;
                    pattern_d   = pattern;
                    idx_d       = '0;
                    addr_d      = base;
                    if (len_eff == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWr;
                        busy_d  = 1'b1;
                        wr_d    = 1'b1;
                        wdata_d = fill_word(mode, pattern, base);
                    end
                end
            end
            StWr: begin
                if (!avm_waitrequest) begin
                    if (last_word) begin
                        state_d = StRd;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        idx_d   = '0;
                        addr_d  = base_q;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        addr_d  = next_addr;
                        wdata_d = fill_word(mode_q, pattern_q, next_addr);
                    end
                end
            end
            StRd: begin
                if (!avm_waitrequest) begin
                    state_d = StRwait;
                    rd_d    = 1'b0;
                    lat_d   = '0;
                end
            end
            StRwait: begin
                if (lat_q == LatLast) begin
                    // addr_q still holds the address of the read being checked
                    if (avm_readdata != fill_word(mode_q, pattern_q, addr_q)) begin
                        if (!err_flag_q) begin
                            first_err_d = addr_q;
                        end
                        err_flag_d = 1'b1;
                        if (err_count_q != CntMax) begin
                            err_count_d = err_count_q + IdxOne;
                        end
                    end
                    if (last_word) begin
                        state_d = StFin;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRd;
                        rd_d    = 1'b1;
                        idx_d   = idx_q + IdxOne;
                        addr_d  = next_addr;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops strobes immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            pattern_q   <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_flag       = err_flag_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign avm_address    = addr_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_writedata  = wdata_q;
    assign avm_chipselect = wr_q | rd_q;
    assign avm_byteenable = {(DATA_W/8){wr_q | rd_q}};

endmodule

// File: tb/tb_ram_fill_check_master.sv
// Directed bench: two masters (read latency 1 and 2) share one RAM model; sel picks the active one.
module tb_ram_fill_check_master;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic          mode = 1'b0;
    logic          stall_en = 1'b0;
    logic          corrupt = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] pattern = '0;
    logic [DW-1:0] rdata;
    logic          wreq;

    logic          d0_busy, d0_done, d0_eflag, d0_cs, d0_wr, d0_rd;
    logic [AW:0]   d0_ecnt;
    logic [AW-1:0] d0_ferr, d0_addr;
    logic [3:0]    d0_be;
    logic [DW-1:0] d0_wd;
    logic          d1_busy, d1_done, d1_eflag, d1_cs, d1_wr, d1_rd;
    logic [AW:0]   d1_ecnt;
    logic [AW-1:0] d1_ferr, d1_addr;
    logic [3:0]    d1_be;
    logic [DW-1:0] d1_wd;

    ram_fill_check_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start & ~sel), .base(base), .len(len),
        .mode(mode), .pattern(pattern), .busy(d0_busy), .done(d0_done), .err_flag(d0_eflag),
        .err_count(d0_ecnt), .first_err_addr(d0_ferr), .avm_address(d0_addr),
        .avm_byteenable(d0_be), .avm_chipselect(d0_cs), .avm_write(d0_wr),
        .avm_writedata(d0_wd), .avm_read(d0_rd), .avm_readdata(rdata),
        .avm_waitrequest(wreq)
    );

    ram_fill_check_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start & sel), .base(base), .len(len),
        .mode(mode), .pattern(pattern), .busy(d1_busy), .done(d1_done), .err_flag(d1_eflag),
        .err_count(d1_ecnt), .first_err_addr(d1_ferr), .avm_address(d1_addr),
        .avm_byteenable(d1_be), .avm_chipselect(d1_cs), .avm_write(d1_wr),
        .avm_writedata(d1_wd), .avm_read(d1_rd), .avm_readdata(rdata),
        .avm_waitrequest(wreq)
    );

    logic          m_busy, m_done, m_eflag, m_cs, m_wr, m_rd;
    logic [AW:0]   m_ecnt;
    logic [AW-1:0] m_ferr, m_addr;
    logic [3:0]    m_be;
    logic [DW-1:0] m_wd;

    assign m_busy  = sel ? d1_busy  : d0_busy;
    assign m_done  = sel ? d1_done  : d0_done;
    assign m_eflag = sel ? d1_eflag : d0_eflag;
    assign m_cs    = sel ? d1_cs    : d0_cs;
    assign m_wr    = sel ? d1_wr    : d0_wr;
    assign m_rd    = sel ? d1_rd    : d0_rd;
    assign m_ecnt  = sel ? d1_ecnt  : d0_ecnt;
    assign m_ferr  = sel ? d1_ferr  : d0_ferr;
    assign m_addr  = sel ? d1_addr  : d0_addr;
    assign m_be    = sel ? d1_be    : d0_be;
    assign m_wd    = sel ? d1_wd    : d0_wd;

    always #5 clk = ~clk;

    // RAM model with fixed read latency taken from the selected master
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rdq0, rdq1;
    int            wcnt = 0;

    assign wreq  = stall_en && m_cs && (wcnt < 3);
    assign rdata = sel ? rdq1 : rdq0;

    always @(posedge clk) begin
        if (m_cs && wreq) wcnt <= wcnt + 1;
        else              wcnt <= 0;
        if (m_wr && !wreq) mem[m_addr] <= m_wd;
        if (m_rd && !wreq) begin
            if (corrupt && (m_addr == 10'h012 || m_addr == 10'h013))
                rdq0 <= mem[m_addr] ^ 32'h1;
            else
                rdq0 <= mem[m_addr];
        end
        rdq1 <= rdq0;
    end

    // Bus monitor: write log, counters and stall-stability watch
    int            cyc = 0, rd_cnt = 0, done_cnt = 0, cs_cyc = 0, viol = 0;
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    int            wlog_t[$];
    logic          stall_prev = 1'b0;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    logic          s_wr, s_rd;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_wr && !wreq) begin
            wlog_a.push_back(m_addr);
            wlog_d.push_back(m_wd);
            wlog_t.push_back(cyc);
        end
        if (m_rd && !wreq) rd_cnt <= rd_cnt + 1;
        if (m_done) done_cnt <= done_cnt + 1;
        if (m_cs) cs_cyc <= cs_cyc + 1;
        if ((m_cs && m_be != 4'hF) || (!m_cs && m_be != 4'h0)) viol <= viol + 1;
        if (stall_prev && (m_addr != s_addr || m_wd != s_wd || m_wr != s_wr || m_rd != s_rd))
            viol <= viol + 1;
        stall_prev <= m_cs && wreq;
        s_addr <= m_addr;
        s_wd   <= m_wd;
        s_wr   <= m_wr;
        s_rd   <= m_rd;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wlog_a.delete();
        wlog_d.delete();
        wlog_t.delete();
    endtask

    task automatic pulse_start(input logic s, input logic [AW-1:0] b, input logic [AW:0] l,
                               input logic m, input logic [DW-1:0] p);
        @(negedge clk);
        sel = s; base = b; len = l; mode = m; pattern = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high, or flags a timeout
    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (m_done) break;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(m_done), 64'd1);
    endtask

    int rd0, dn0, cs0, v0;

    initial begin
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_busy", 64'(m_busy), 0);
        check("rst_done", 64'(m_done), 0);
        check("rst_cs", 64'({d0_cs, d1_cs}), 0);
        check("rst_be", 64'({d0_be, d1_be}), 0);
        check("rst_ecnt", 64'(m_ecnt), 0);
        check("rst_addr", 64'(m_addr), 0);
        reset_n = 1'b1;

        // 1: basic fill/check, latency 1, no stalls
        clear_logs(); rd0 = rd_cnt; dn0 = done_cnt;
        pulse_start(1'b0, 10'h010, 11'd4, 1'b0, 32'hA5A5A5A5);
        wait_done("t1");
        check("t1_busy_at_done", 64'(m_busy), 0);
        check("t1_ecnt", 64'(m_ecnt), 0);
        check("t1_eflag", 64'(m_eflag), 0);
        check("t1_nwr", 64'(wlog_a.size()), 4);
        check("t1_wr0_addr", 64'(wlog_a[0]), 64'h010);
        check("t1_wr3_addr", 64'(wlog_a[3]), 64'h013);
        check("t1_wr_data", 64'(wlog_d[2]), 64'hA5A5A5A5);
        check("t1_b2b", 64'(wlog_t[3] - wlog_t[0]), 3);
        @(negedge clk);
        check("t1_nrd", 64'(rd_cnt - rd0), 4);
        check("t1_done_pulse", 64'(m_done), 0);

        // 2: wrap-around with address-xor data
        clear_logs();
        pulse_start(1'b0, 10'h3FE, 11'd4, 1'b1, 32'h0000FFFF);
        wait_done("t2");
        check("t2_ecnt", 64'(m_ecnt), 0);
        check("t2_a0", 64'(wlog_a[0]), 64'h3FE);
        check("t2_a1", 64'(wlog_a[1]), 64'h3FF);
        check("t2_a2", 64'(wlog_a[2]), 64'h000);
        check("t2_a3", 64'(wlog_a[3]), 64'h001);
        check("t2_d0", 64'(wlog_d[0]), 64'h0000FC01);
        check("t2_d1", 64'(wlog_d[1]), 64'h0000FC00);
        check("t2_d2", 64'(wlog_d[2]), 64'h0000FFFF);
        check("t2_d3", 64'(wlog_d[3]), 64'h0000FFFE);

        // 3: corrupted reads at 0x012 and 0x013
        corrupt = 1'b1;
        pulse_start(1'b0, 10'h010, 11'd4, 1'b0, 32'hA5A5A5A5);
        wait_done("t3");
        corrupt = 1'b0;
        check("t3_ecnt", 64'(m_ecnt), 2);
        check("t3_ferr", 64'(m_ferr), 64'h012);
        check("t3_eflag", 64'(m_eflag), 1);
        repeat (5) @(negedge clk);
        check("t3_hold_ecnt", 64'(m_ecnt), 2);

        // 4: three-cycle stalls on every access, latency 2
        clear_logs(); v0 = viol; rd0 = rd_cnt;
        stall_en = 1'b1;
        pulse_start(1'b1, 10'h010, 11'd4, 1'b0, 32'hA5A5A5A5);
        wait_done("t4");
        check("t4_ecnt", 64'(m_ecnt), 0);
        check("t4_eflag", 64'(m_eflag), 0);
        check("t4_ferr", 64'(m_ferr), 0);
        check("t4_nwr", 64'(wlog_a.size()), 4);
        check("t4_stall_gap", 64'(wlog_t[1] - wlog_t[0]), 4);
        check("t4_wr3_addr", 64'(wlog_a[3]), 64'h013);
        @(negedge clk);
        stall_en = 1'b0;
        check("t4_nrd", 64'(rd_cnt - rd0), 4);
        check("t4_stable", 64'(viol - v0), 0);

        // 5: len=0 gives done one cycle after start with no strobes
        cs0 = cs_cyc; dn0 = done_cnt;
        pulse_start(1'b0, 10'h055, 11'd0, 1'b0, 32'h12345678);
        check("t5_len0_done", 64'(m_done), 1);
        check("t5_len0_busy", 64'(m_busy), 0);
        @(negedge clk);
        check("t5_len0_nostrobe", 64'(cs_cyc - cs0), 0);
        // start while busy and during the done cycle is ignored
        clear_logs(); dn0 = done_cnt;
        pulse_start(1'b0, 10'h020, 11'd4, 1'b0, 32'h0F0F0F0F);
        @(negedge clk);
        start = 1'b1; base = 10'h100; len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_fin_start_ignored", 64'(m_busy), 0);
        repeat (10) @(negedge clk);
        check("t5_one_done", 64'(done_cnt - dn0), 1);
        check("t5_nwr", 64'(wlog_a.size()), 4);
        check("t5_first_addr", 64'(wlog_a[0]), 64'h020);

        // 6: reset during the write phase
        stall_en = 1'b1;
        pulse_start(1'b0, 10'h030, 11'd8, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check("t6_in_wr", 64'(m_wr), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_wr", 64'(m_wr), 0);
        check("t6_rst_busy", 64'(m_busy), 0);
        check("t6_rst_cs", 64'(m_cs), 0);
        check("t6_rst_addr", 64'(m_addr), 0);
        check("t6_rst_wd", 64'(m_wd), 0);
        @(negedge clk);
        stall_en = 1'b0;
        reset_n = 1'b1;
        clear_logs();
        pulse_start(1'b0, 10'h050, 11'd2, 1'b1, 32'h00000000);
        wait_done("t6");
        check("t6_ecnt", 64'(m_ecnt), 0);
        check("t6_nwr", 64'(wlog_a.size()), 2);
        check("t6_d1", 64'(wlog_d[1]), 64'h051);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
